framebuffer_engine: RTL and testbench

//  Parametrised drawing engine for the row-per-word video memory: executes DRAW (multi-row XOR sprite),

---
 rtl/framebuffer_engine_pkg.sv | 10 +
 rtl/fb_row_placer.sv | 16 +
 rtl/framebuffer_engine.sv | 172 +++++++++++++++++
 tb/tb_framebuffer_engine.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/framebuffer_engine_pkg.sv
// framebuffer_engine_pkg: command op codes and engine state encoding shared by the drawing engine.
package framebuffer_engine_pkg;
    localparam logic [2:0] OP_DRAW  = 3'd0;
    localparam logic [2:0] OP_CLEAR = 3'd1;
    localparam logic [2:0] OP_SCR_L = 3'd2;
    localparam logic [2:0] OP_SCR_R = 3'd3;
    localparam logic [2:0] OP_SCR_U = 3'd4;
    localparam logic [2:0] OP_SCR_D = 3'd5;
    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_CLR} state_t;
endpackage

// File: rtl/fb_row_placer.sv
// fb_row_placer: positions one sprite row at a column inside a video row, rotating or clipping at the right edge.
module fb_row_placer #(
    parameter int COLS = 128,
    parameter int SPR_W = 16,
    localparam int CW = $clog2(COLS)
) (
    input  logic [SPR_W-1:0] spr,
    input  logic [CW-1:0]    col,
    input  logic             wrap,
    output logic [COLS-1:0]  placed
);
    logic [COLS-1:0] base;
    assign base = {spr, {(COLS-SPR_W){1'b0}}};
    // col = 0 shifts the wrapped part by COLS, which yields zero
    assign placed = (base >> col) | (wrap ? base << (COLS - int'(col)) : '0);
endmodule

// File: rtl/framebuffer_engine.sv
// framebuffer_engine: DRAW/CLEAR/SCROLL engine driving write port A of a row-per-word video RAM.
module framebuffer_engine
    import framebuffer_engine_pkg::*;
#(
    parameter int COLS = 128,
    parameter int ROWS = 64,
    parameter int SPR_W = 16,
    parameter int SPR_H = 16,
    localparam int AW = $clog2(ROWS),
    localparam int CW = $clog2(COLS),
    localparam int HW = $clog2(SPR_H+1)
) (
    input  logic             clk_100mhz,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [AW-1:0]    cmd_row,
    input  logic [CW-1:0]    cmd_col,
    input  logic [HW-1:0]    cmd_height,
    input  logic [CW-1:0]    cmd_amount,
    input  logic             cmd_wrap,
    output logic             spr_req,
    output logic [HW-1:0]    spr_idx,
    input  logic [SPR_W-1:0] spr_data,
    output logic [AW-1:0]    mem_addr,
    output logic             mem_we,
    output logic [COLS-1:0]  mem_wdata,
    input  logic [COLS-1:0]  mem_rdata,
    output logic             busy,
    output logic             done,
    output logic             collision
);
    state_t          state;
    logic [2:0]      op;
    logic [AW-1:0]   row, r, nxt_r, dst, first_r;
    logic [CW-1:0]   col, amt;
    logic [HW-1:0]   h, ri, nxt_i, cmd_h;
    logic            wrap, zero, last_row, draw_fin, cmd_scroll;
    logic [AW:0]     cmd_src, nxt_src;
    logic [COLS-1:0] placed;

    // {source row in range, source address} for the row r about to be processed
    function automatic logic [AW:0] src_of(input logic [2:0] o, input logic [AW-1:0] rr, input logic [CW-1:0] n);
        int s;
        s = o == OP_SCR_U ? int'(rr) + int'(n) : o == OP_SCR_D ? int'(rr) - int'(n) : int'(rr);
        return {s >= 0 && s < ROWS, AW'(s)};
    endfunction

    fb_row_placer #(.COLS(COLS), .SPR_W(SPR_W)) u_placer (
        .spr(spr_data),
        .col(col),
        .wrap(wrap),
        .placed(placed)
    );

    assign cmd_ready = state == S_IDLE;
    assign busy = ~cmd_ready;

    always_comb begin
        cmd_h = cmd_height > HW'(SPR_H) ? HW'(SPR_H) : cmd_height;
        cmd_scroll = cmd_op >= OP_SCR_L && cmd_op <= OP_SCR_D && cmd_amount != '0;
        first_r = cmd_op == OP_SCR_D ? AW'(ROWS-1) : '0;
        cmd_src = src_of(cmd_op, first_r, cmd_amount);
        nxt_r = op == OP_SCR_D ? r - 1'b1 : r + 1'b1;
        last_row = r == (op == OP_SCR_D ? '0 : AW'(ROWS-1));
        nxt_src = src_of(op, nxt_r, amt);
        nxt_i = ri + 1'b1;
        dst = row + AW'(ri);
        draw_fin = nxt_i == h || (!wrap && int'(row) + int'(nxt_i) >= ROWS);
    end

    always_comb begin
        mem_wdata = '0;
        if (state == S_WR)
            mem_wdata = op == OP_DRAW ? mem_rdata ^ placed :
                        op == OP_SCR_L ? mem_rdata << amt :
                        op == OP_SCR_R ? mem_rdata >> amt :
                        zero ? '0 : mem_rdata;
    end

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            state <= S_IDLE;
            mem_we <= 1'b0;
            mem_addr <= '0;
            spr_req <= 1'b0;
            spr_idx <= '0;
            done <= 1'b0;
            collision <= 1'b0;
            op <= '0;
            row <= '0;
            col <= '0;
            amt <= '0;
            h <= '0;
            ri <= '0;
            r <= '0;
            wrap <= 1'b0;
            zero <= 1'b0;
        end else begin
            done <= 1'b0;
            spr_req <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                S_IDLE: if (cmd_valid) begin
                    op <= cmd_op;
                    row <= cmd_row;
                    col <= cmd_col;
                    amt <= cmd_amount;
                    h <= cmd_h;
                    wrap <= cmd_wrap;
                    ri <= '0;
                    r <= first_r;
                    if (cmd_op == OP_DRAW) collision <= 1'b0;
                    if (cmd_op == OP_DRAW && cmd_h != '0) begin
                        state <= S_RD;
                        mem_addr <= cmd_row;
                        spr_req <= 1'b1;
                        spr_idx <= '0;
                    end else if (cmd_op == OP_CLEAR) begin
                        state <= S_CLR;
                        mem_addr <= '0;
                        mem_we <= 1'b1;
                    end else if (cmd_scroll) begin
                        zero <= !cmd_src[AW];
                        state <= cmd_src[AW] ? S_RD : S_WR;
                        mem_addr <= cmd_src[AW] ? cmd_src[AW-1:0] : first_r;
                        mem_we <= !cmd_src[AW];
                    end else begin
                        done <= 1'b1;
                    end
                end
                S_RD: begin
                    state <= S_WR;
                    mem_we <= 1'b1;
                    mem_addr <= op == OP_DRAW ? dst : r;
                end
                S_WR: if (op == OP_DRAW) begin
                    collision <= collision | |(mem_rdata & placed);
                    if (draw_fin) begin
                        state <= S_IDLE;
                        done <= 1'b1;
                    end else begin
                        state <= S_RD;
                        ri <= nxt_i;
                        mem_addr <= row + AW'(nxt_i);
                        spr_req <= 1'b1;
                        spr_idx <= nxt_i;
                    end
                end else if (last_row) begin
                    state <= S_IDLE;
                    done <= 1'b1;
                end else begin
                    r <= nxt_r;
                    zero <= !nxt_src[AW];
                    state <= nxt_src[AW] ? S_RD : S_WR;
                    mem_addr <= nxt_src[AW] ? nxt_src[AW-1:0] : nxt_r;
                    mem_we <= !nxt_src[AW];
                end
                S_CLR: if (r == AW'(ROWS-1)) begin
                    state <= S_IDLE;
                    done <= 1'b1;
                end else begin
                    r <= r + 1'b1;
                    mem_addr <= r + 1'b1;
                    mem_we <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_framebuffer_engine.sv
// tb_framebuffer_engine: random and directed commands against a whole-frame reference model.
module tb_framebuffer_engine;
    import framebuffer_engine_pkg::*;
    localparam int COLS = 128, ROWS = 64, SPR_W = 16, SPR_H = 16, AW = 6, CW = 7, HW = 5;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic cmd_valid = 1'b0, cmd_ready, cmd_wrap = 1'b0;
    logic [2:0] cmd_op = '0;
    logic [AW-1:0] cmd_row = '0;
    logic [CW-1:0] cmd_col = '0, cmd_amount = '0;
    logic [HW-1:0] cmd_height = '0;
    logic spr_req, mem_we, busy, done, collision;
    logic [HW-1:0] spr_idx;
    logic [SPR_W-1:0] spr_data;
    logic [AW-1:0] mem_addr;
    logic [COLS-1:0] mem_wdata, mem_rdata;

    logic [COLS-1:0] ram [ROWS];
    logic [COLS-1:0] img [ROWS];
    logic [COLS-1:0] mdl [ROWS];
    logic [SPR_W-1:0] spr_rom [32];
    logic mdl_coll = 1'b0, load = 1'b0;
    int checks = 0, errors = 0, we_cnt = 0, req_cnt = 0;

    framebuffer_engine dut (
        .clk_100mhz(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_height(cmd_height),
        .cmd_amount(cmd_amount), .cmd_wrap(cmd_wrap), .spr_req(spr_req), .spr_idx(spr_idx),
        .spr_data(spr_data), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .done(done), .collision(collision)
    );

    always @(posedge clk) begin
        if (load) for (int i = 0; i < ROWS; i++) ram[i] <= img[i];
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
        spr_data <= spr_rom[spr_idx];
    end

    always @(negedge clk) begin
        if (mem_we) we_cnt++;
        if (spr_req) req_cnt++;
    end

    task automatic check(input string tag, input logic [COLS-1:0] got, input logic [COLS-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < ROWS; i++)
            img[i] = mode == 0 ? {$urandom, $urandom, $urandom, $urandom} : mode == 1 ? COLS'(i + 1) : COLS'(1);
        for (int i = 0; i < ROWS; i++) mdl[i] = img[i];
        @(negedge clk) load = 1'b1;
        @(negedge clk) load = 1'b0;
    endtask

    task automatic check_rows(input string tag);
        for (int i = 0; i < ROWS; i++) check($sformatf("%s.row%0d", tag, i), ram[i], mdl[i]);
    endtask

    // Reference: whole-frame effect of one command plus expected cycle and strobe counts
    task automatic model(input logic [2:0] op, input int row, col, h, amt, input logic wrap,
                         output int el, output int ew, output int er);
        logic [COLS-1:0] old [ROWS];
        logic [COLS-1:0] pl;
        int hc, d, c, s;
        for (int i = 0; i < ROWS; i++) old[i] = mdl[i];
        el = 1; ew = 0; er = 0;
        if (op == OP_DRAW) begin
            mdl_coll = 1'b0;
            hc = h > SPR_H ? SPR_H : h;
            for (int i = 0; i < hc; i++) begin
                d = row + i;
                if (!wrap && d >= ROWS) break;
                d = d % ROWS;
                pl = '0;
                for (int j = 0; j < SPR_W; j++) begin
                    c = col + j;
                    if (c >= COLS && !wrap) continue;
                    if (spr_rom[i][SPR_W-1-j]) pl[COLS-1-(c % COLS)] = 1'b1;
                end
                if ((mdl[d] & pl) != '0) mdl_coll = 1'b1;
                mdl[d] ^= pl;
                el += 2; ew++; er++;
            end
        end else if (op == OP_CLEAR) begin
            for (int i = 0; i < ROWS; i++) mdl[i] = '0;
            el += ROWS; ew = ROWS;
        end else if (op >= OP_SCR_L && op <= OP_SCR_D && amt != 0) begin
            for (int i = 0; i < ROWS; i++) begin
                s = op == OP_SCR_U ? i + amt : op == OP_SCR_D ? i - amt : i;
                mdl[i] = op == OP_SCR_L ? old[i] << amt : op == OP_SCR_R ? old[i] >> amt :
                         (s >= 0 && s < ROWS) ? old[s] : '0;
                el += (s >= 0 && s < ROWS) ? 2 : 1;
                ew++;
            end
        end
    endtask

    task automatic run(input string tag, input logic [2:0] op, input int row, col, h, amt, input logic wrap);
        int el, ew, er, lat;
        model(op, row, col, h, amt, wrap, el, ew, er);
        @(negedge clk);
        cmd_op = op; cmd_row = AW'(row); cmd_col = CW'(col); cmd_height = HW'(h);
        cmd_amount = CW'(amt); cmd_wrap = wrap; cmd_valid = 1'b1;
        we_cnt = 0; req_cnt = 0;
        @(posedge clk) #1 cmd_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 400);
        check({tag, ".lat"}, COLS'(lat), COLS'(el));
        check({tag, ".writes"}, COLS'(we_cnt), COLS'(ew));
        check({tag, ".sprreq"}, COLS'(req_cnt), COLS'(er));
        check({tag, ".coll"}, COLS'(collision), COLS'(mdl_coll));
        check({tag, ".ready"}, COLS'(cmd_ready), COLS'(1));
        check_rows(tag);
    endtask

    initial begin
        int n, op, amt;
        for (int i = 0; i < 32; i++) spr_rom[i] = '0;
        for (int i = 0; i < ROWS; i++) mdl[i] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst.ready", COLS'(cmd_ready), COLS'(1));
        check("rst.busy", COLS'(busy), COLS'(0));
        check("rst.we", COLS'(mem_we), COLS'(0));
        check("rst.req", COLS'(spr_req), COLS'(0));
        check("rst.done", COLS'(done), COLS'(0));
        check("rst.coll", COLS'(collision), COLS'(0));
        check("rst.addr", COLS'(mem_addr), COLS'(0));
        check("rst.wdata", mem_wdata, COLS'(0));
        check("rst.idx", COLS'(spr_idx), COLS'(0));

        fill(0);
        run("clear", OP_CLEAR, 0, 0, 0, 0, 1'b0);
        spr_rom[0] = 16'hF00F;
        run("draw1", OP_DRAW, 5, 0, 1, 0, 1'b0);
        check("draw1.row5", ram[5], {16'hF00F, 112'h0});
        run("draw2", OP_DRAW, 5, 0, 1, 0, 1'b0);
        check("draw2.coll1", COLS'(collision), COLS'(1));

        @(negedge clk);
        cmd_op = OP_CLEAR; cmd_valid = 1'b1;
        @(posedge clk) #1 cmd_valid = 1'b0;
        n = 0;
        while (n < 3) begin
            @(negedge clk);
            if (mem_we) n++;
            else if (done) break;
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rstmid.we", COLS'(mem_we), COLS'(0));
        check("rstmid.ready", COLS'(cmd_ready), COLS'(1));
        check("rstmid.done", COLS'(done), COLS'(0));
        check("rstmid.coll", COLS'(collision), COLS'(0));
        rst = 1'b0;
        mdl_coll = 1'b0;
        for (int i = 0; i < 3; i++) mdl[i] = '0;
        check_rows("rstmid");

        spr_rom[0] = 16'hFFFF; spr_rom[1] = 16'hFFFF;
        run("wrapdraw", OP_DRAW, 63, 120, 2, 0, 1'b1);
        check("wrapdraw.r63", ram[63], {8'hFF, 112'h0, 8'hFF});
        check("wrapdraw.r0", ram[0], {8'hFF, 112'h0, 8'hFF});
        run("clipdraw", OP_DRAW, 63, 120, 2, 0, 1'b0);

        fill(1);
        run("scr_d4", OP_SCR_D, 0, 0, 0, 4, 1'b0);
        check("scr_d4.r10", ram[10], COLS'(7));
        fill(1);
        run("scr_u64", OP_SCR_U, 0, 0, 0, 64, 1'b0);
        fill(2);
        run("scr_l4", OP_SCR_L, 0, 0, 0, 4, 1'b0);
        check("scr_l4.r7", ram[7], COLS'(16'h10));
        fill(2);
        run("scr_r130", OP_SCR_R, 0, 0, 0, 130, 1'b0);
        check("scr_r130.r9", ram[9], COLS'(0));
        run("scr_n0", OP_SCR_L, 0, 0, 0, 0, 1'b0);
        run("nop7", 3'd7, 0, 0, 0, 0, 1'b0);
        run("draw_h0", OP_DRAW, 3, 3, 0, 0, 1'b1);

        for (int it = 0; it < 40; it++) begin
            if (it % 8 == 0) fill(0);
            for (int i = 0; i < SPR_H; i++) spr_rom[i] = SPR_W'($urandom);
            op = $urandom_range(0, 7);
            amt = $urandom_range(0, 3) == 0 ? $urandom_range(0, COLS-1) : $urandom_range(0, 8);
            run($sformatf("rnd%0d", it), 3'(op), $urandom_range(0, ROWS-1), $urandom_range(0, COLS-1),
                $urandom_range(0, 20), amt, 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
